// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {S_CLEAR, S_READY} rf_state_t;

    // Index width for an n-entry array; a 1-entry file still needs one bit.
    function automatic int addr_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: range check, zero-register mask, init gating, optional write bypass.
// Bypass is compiled in when REGFILE_BYPASS_EN is defined.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int NUM_OF_SETS    = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int ZERO_REG_EN    = 1,
    parameter int AW             = 5
) (
    input  logic                      ready,
    input  logic [DATA_BUS_WIDTH-1:0] mem [NUM_OF_SETS],
    input  logic [AW-1:0]             rd_addr,
    input  logic                      wr_commit,
    input  logic [AW-1:0]             wr_addr,
    input  logic [DATA_BUS_WIDTH-1:0] wr_data,
    output logic [DATA_BUS_WIDTH-1:0] rd_data
);

    logic in_range;
    logic is_zero_reg;

    assign in_range    = (32'(rd_addr) < 32'(NUM_OF_SETS));
    assign is_zero_reg = (ZERO_REG_EN != 0) && (rd_addr == '0);

    always_comb begin
        rd_data = '0;
        if (ready && in_range && !is_zero_reg) begin
            rd_data = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
            // wr_commit already excludes dropped writes, so only real updates forward.
            if (wr_commit && (wr_addr == rd_addr)) begin
                rd_data = wr_data;
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_commit, wr_addr, wr_data};
`endif

endmodule

// File: rtl/multi_port_register_file.sv
// Architectural register file: NUM_RD_PORTS async reads, one sync write, post-reset clear sweep.
// Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
//
// state   | meaning
// S_CLEAR | sweeping INIT_VALUE into every entry; user writes dropped, reads return 0
// S_READY | normal operation until the next reset
module multi_port_register_file
    import regfile_pkg::*;
#(
    parameter int                          NUM_OF_SETS    = 32,
    parameter int                          DATA_BUS_WIDTH = 32,
    parameter int                          NUM_RD_PORTS   = 2,
    parameter int                          ZERO_REG_EN    = 1,
    parameter logic [DATA_BUS_WIDTH-1:0]   INIT_VALUE     = '0,
    localparam int                         AW             = addr_width(NUM_OF_SETS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_enable,
    input  logic [AW-1:0]                          wr_addr,
    input  logic [DATA_BUS_WIDTH-1:0]              wr_data,
    input  logic [NUM_RD_PORTS*AW-1:0]             rd_addr,
    output logic [NUM_RD_PORTS*DATA_BUS_WIDTH-1:0] rd_data,
    output logic                                   init_done
);

    localparam logic [AW-1:0] LAST = AW'(NUM_OF_SETS - 1);

    rf_state_t                 state;
    logic [AW-1:0]             clr_ptr;
    logic [DATA_BUS_WIDTH-1:0] mem [NUM_OF_SETS];
    logic                      ready;
    logic                      wr_commit;

    assign ready     = (state == S_READY);
    assign init_done = ready;
    assign wr_commit = ready && wr_enable
                     && (32'(wr_addr) < 32'(NUM_OF_SETS))
                     && !((ZERO_REG_EN != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_ptr == LAST) begin
                        state <= S_READY;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: state <= S_READY;
            endcase
        end
    end

    // Storage has no reset; the clear sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_ptr] <= INIT_VALUE;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        rf_read_port #(
            .NUM_OF_SETS    (NUM_OF_SETS),
            .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
            .ZERO_REG_EN    (ZERO_REG_EN),
            .AW             (AW)
        ) u_rd (
            .ready     (ready),
            .mem       (mem),
            .rd_addr   (rd_addr[p*AW +: AW]),
            .wr_commit (wr_commit),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_data   (rd_data[p*DATA_BUS_WIDTH +: DATA_BUS_WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench: default 32-entry file plus a 20-entry, ZERO_REG_EN=0, INIT_VALUE=0x55 build.
module tb_multi_port_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we, b_we;
    logic [4:0]  a_wa, b_wa;
    logic [31:0] a_wd, b_wd;
    logic [9:0]  a_ra, b_ra;
    logic [63:0] a_rd, b_rd;
    logic        a_done, b_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_port_register_file dut_a (
        .clk       (clk),
        .rst       (rst),
        .wr_enable (a_we),
        .wr_addr   (a_wa),
        .wr_data   (a_wd),
        .rd_addr   (a_ra),
        .rd_data   (a_rd),
        .init_done (a_done)
    );

    multi_port_register_file #(
        .NUM_OF_SETS (20),
        .ZERO_REG_EN (0),
        .INIT_VALUE  (32'h55)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .wr_enable (b_we),
        .wr_addr   (b_wa),
        .wr_data   (b_wd),
        .rd_addr   (b_ra),
        .rd_data   (b_rd),
        .init_done (b_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        rst  = 1'b0;
        a_we = 1'b0; a_wa = '0; a_wd = '0; a_ra = '0;
        b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_done_a", 32'(a_done), 32'd0);
        check("rst_done_b", 32'(b_done), 32'd0);

        // Writes to x7 held active through the whole sweep must be dropped.
        a_we = 1'b1; a_wa = 5'd7; a_wd = 32'hAA;
        b_we = 1'b1; b_wa = 5'd7; b_wd = 32'hAA;
        b_ra = {5'd0, 5'd3};
        rst  = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("sweep_done_a_e%0d", n), 32'(a_done), (n >= 32) ? 32'd1 : 32'd0);
            if (n <= 21)
                check($sformatf("sweep_done_b_e%0d", n), 32'(b_done), (n >= 20) ? 32'd1 : 32'd0);
            if (n == 5)
                check("clear_gates_read_b", b_rd[31:0], 32'd0);
            if (n == 20)
                b_we = 1'b0;
        end
        a_we = 1'b0;

        for (int i = 0; i < 32; i++) begin
            a_ra = {5'(i), 5'(i)};
            b_ra = {5'(i), 5'(i)};
            #1;
            check($sformatf("init_a_p0_%0d", i), a_rd[31:0], 32'd0);
            check($sformatf("init_a_p1_%0d", i), a_rd[63:32], 32'd0);
            check($sformatf("init_b_p0_%0d", i), b_rd[31:0], (i < 20) ? 32'h55 : 32'd0);
        end

        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF; a_ra = {5'd5, 5'd5};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x5_same_cycle", a_rd[31:0], 32'hDEADBEEF);
`else
        check("x5_same_cycle", a_rd[31:0], 32'd0);
`endif
        @(negedge clk);
        a_we = 1'b0;
        #1;
        check("x5_p0", a_rd[31:0], 32'hDEADBEEF);
        check("x5_p1", a_rd[63:32], 32'hDEADBEEF);

        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'h12345678; a_ra = '0;
        b_we = 1'b1; b_wa = 5'd0; b_wd = 32'h12345678; b_ra = '0;
        #1;
        check("x0_zero_same_cycle_a", a_rd[31:0], 32'd0);
`ifdef REGFILE_BYPASS_EN
        check("x0_same_cycle_b", b_rd[31:0], 32'h12345678);
`else
        check("x0_same_cycle_b", b_rd[31:0], 32'h55);
`endif
        @(negedge clk);
        a_we = 1'b0; b_we = 1'b0;
        #1;
        check("x0_zero_a", a_rd[31:0], 32'd0);
        check("x0_normal_b", b_rd[31:0], 32'h12345678);

        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd31; a_wd = 32'hCAFEF00D;
        @(negedge clk);
        a_we = 1'b0; a_ra = {5'd31, 5'd30};
        #1;
        check("x31_p1", a_rd[63:32], 32'hCAFEF00D);
        check("x30_p0", a_rd[31:0], 32'd0);

        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            b_we = 1'b1; b_wa = 5'(i); b_wd = 32'hB0000000 + 32'(i);
        end
        @(negedge clk);
        b_wa = 5'd25; b_wd = 32'hFFFFFFFF; b_ra = {5'd5, 5'd25};
        #1;
        check("oor_same_cycle_b", b_rd[31:0], 32'd0);
        @(negedge clk);
        b_we = 1'b0;
        #1;
        check("oor_read_b", b_rd[31:0], 32'd0);
        check("oor_no_alias_b", b_rd[63:32], 32'hB0000005);
        for (int i = 1; i < 20; i++) begin
            b_ra = {5'(i), 5'd0};
            #1;
            check($sformatf("fill_b_%0d", i), b_rd[63:32], 32'hB0000000 + 32'(i));
        end
        check("fill_b_x0", b_rd[31:0], 32'h12345678);

        // Asynchronous reset from S_READY, then a second reset at clr_ptr=10.
        a_ra = {5'd5, 5'd5};
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst_done_a", 32'(a_done), 32'd0);
        check("async_rst_read_a", a_rd[31:0], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_sweep_done_a", 32'(a_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("resweep_done_a_e%0d", n), 32'(a_done), (n >= 32) ? 32'd1 : 32'd0);
        end
        b_ra = {5'd5, 5'd5};
        #1;
        check("resweep_x5_a", a_rd[31:0], 32'd0);
        check("resweep_x5_b", b_rd[63:32], 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
